// File: rtl/serial_uart_bridge.sv
// serial_uart_bridge
//   Device-side endpoint of the processor's byte-wide serial IO port.
//   Processor bytes are buffered in a TX FIFO and sent as 8N1 UART frames;
//   received UART frames are buffered in an RX FIFO and presented show-ahead.
//   Optional build macro: SERIAL_LOOPBACK_EN -- when defined, the receiver is
//   fed from the internal TX line register instead of uart_rx_in.
//
// Processor handshake (strobe based, one byte per edge):
//   A byte moves into the TX FIFO on a rising clock edge where
//   proc_wren_in && proc_ready_out. The RX FIFO head (proc_data_out) is
//   consumed on a rising edge where proc_rden_in && proc_valid_out. A strobe
//   with its qualifier low does nothing: writes while full are dropped
//   silently, reads while empty are ignored. proc_data_out is stable and
//   meaningful whenever proc_valid_out is high.
module serial_uart_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 3
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] proc_data_out,
  output logic       proc_valid_out,
  output logic       proc_ready_out,
  input  logic [7:0] proc_data_in,
  input  logic       proc_wren_in,
  input  logic       proc_rden_in,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  input  logic       err_clear_in,
  output logic       rx_overrun_out,
  output logic       frame_err_out
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Pointers carry one extra bit: equal low bits with different MSBs means full.
  function automatic logic ptr_full(input logic [FIFO_AW:0] wr, input logic [FIFO_AW:0] rd);
    return (wr[FIFO_AW] != rd[FIFO_AW]) && (wr[FIFO_AW-1:0] == rd[FIFO_AW-1:0]);
  endfunction

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       tx_mem [DEPTH];
  logic [FIFO_AW:0] tx_wr_ptr;
  logic [FIFO_AW:0] tx_rd_ptr;
  logic [FIFO_AW:0] tx_wr_next;
  logic [FIFO_AW:0] tx_rd_next;
  logic             tx_ready_q;
  logic             tx_empty;
  logic             tx_push;
  logic             tx_pop;
  logic [7:0]       tx_head;

  uart_state_t      tx_state;
  logic [BW-1:0]    tx_baud;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_line;

  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_push  = proc_wren_in && tx_ready_q;
  assign tx_pop   = (tx_state == ST_IDLE) && !tx_empty;
  assign tx_head  = tx_mem[tx_rd_ptr[FIFO_AW-1:0]];

  // Next TX pointer values; the ready flag is registered from these.
  always_comb begin
    tx_wr_next = tx_wr_ptr + {{FIFO_AW{1'b0}}, tx_push};
    tx_rd_next = tx_rd_ptr + {{FIFO_AW{1'b0}}, tx_pop};
  end

  // TX FIFO pointers and registered not-full flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      tx_wr_ptr  <= tx_wr_next;
      tx_rd_ptr  <= tx_rd_next;
      tx_ready_q <= !ptr_full(tx_wr_next, tx_rd_next);
    end
  end

  // TX FIFO storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr[FIFO_AW-1:0]] <= proc_data_in;
  end

  // ---------------------------------------------------------------------------
  // TX FSM: each of START / DATA(x8) / STOP lasts CLKS_PER_BIT clocks.
  // The line register is updated together with the state so it is glitch-free.
  // ---------------------------------------------------------------------------
  // TX serializer state machine with registered line output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= ST_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          tx_line <= 1'b1;
          if (!tx_empty) begin
            tx_shift <= tx_head;
            tx_baud  <= BIT_LAST;
            tx_line  <= 1'b0;
            tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_baud == '0) begin
            tx_baud  <= BIT_LAST;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_state <= ST_DATA;
          end else begin
            tx_baud <= tx_baud - 1'b1;
          end
        end
        ST_DATA: begin
          if (tx_baud == '0) begin
            tx_baud <= BIT_LAST;
            if (tx_bit == 3'd7) begin
              tx_line  <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_line  <= tx_shift[1];
            end
          end else begin
            tx_baud <= tx_baud - 1'b1;
          end
        end
        ST_STOP: begin
          if (tx_baud == '0) begin
            tx_state <= ST_IDLE;
          end else begin
            tx_baud <= tx_baud - 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  assign uart_tx_out = tx_line;

  // ---------------------------------------------------------------------------
  // RX input selection and synchronizer
  // ---------------------------------------------------------------------------
  logic rx_src;
  logic rx_meta;
  logic rx_sync;

`ifdef SERIAL_LOOPBACK_EN
  logic unused_rx_pin;
  assign unused_rx_pin = uart_rx_in;
  assign rx_src        = tx_line;
`else
  assign rx_src = uart_rx_in;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM: start edge, half-bit confirm, then mid-bit samples.
  // rx_armed requires the line to be seen high in IDLE before a new start,
  // so a line stuck low after a framing error cannot retrigger.
  // ---------------------------------------------------------------------------
  uart_state_t   rx_state;
  logic [BW-1:0] rx_baud;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_armed;
  logic          rx_stop_done;
  logic          rx_good;
  logic          rx_bad;

  assign rx_stop_done = (rx_state == ST_STOP) && (rx_baud == '0);
  assign rx_good      = rx_stop_done && rx_sync;
  assign rx_bad       = rx_stop_done && !rx_sync;

  // RX deserializer state machine.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state <= ST_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_armed <= 1'b0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (rx_sync) begin
            rx_armed <= 1'b1;
          end else if (rx_armed) begin
            rx_baud  <= HALF_LAST;
            rx_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_baud == '0) begin
            if (rx_sync) begin
              rx_armed <= 1'b0;
              rx_state <= ST_IDLE;
            end else begin
              rx_baud  <= BIT_LAST;
              rx_bit   <= '0;
              rx_state <= ST_DATA;
            end
          end else begin
            rx_baud <= rx_baud - 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_baud == '0) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_baud  <= BIT_LAST;
            if (rx_bit == 3'd7) begin
              rx_state <= ST_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_baud <= rx_baud - 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_baud == '0) begin
            rx_armed <= 1'b0;
            rx_state <= ST_IDLE;
          end else begin
            rx_baud <= rx_baud - 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (show-ahead)
  // ---------------------------------------------------------------------------
  logic [7:0]       rx_mem [DEPTH];
  logic [FIFO_AW:0] rx_wr_ptr;
  logic [FIFO_AW:0] rx_rd_ptr;
  logic [FIFO_AW:0] rx_wr_next;
  logic [FIFO_AW:0] rx_rd_next;
  logic             rx_valid_q;
  logic             rx_full;
  logic             rx_pop;
  logic             rx_push;
  logic             overrun_set;

  assign rx_full     = ptr_full(rx_wr_ptr, rx_rd_ptr);
  assign rx_pop      = proc_rden_in && rx_valid_q;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rx_push     = rx_good && (!rx_full || rx_pop);
  assign overrun_set = rx_good && rx_full && !rx_pop;

  // Next RX pointer values; the valid flag is registered from these.
  always_comb begin
    rx_wr_next = rx_wr_ptr + {{FIFO_AW{1'b0}}, rx_push};
    rx_rd_next = rx_rd_ptr + {{FIFO_AW{1'b0}}, rx_pop};
  end

  // RX FIFO pointers and registered non-empty flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_wr_ptr  <= rx_wr_next;
      rx_rd_ptr  <= rx_rd_next;
      rx_valid_q <= (rx_wr_next != rx_rd_next);
    end
  end

  // RX FIFO storage; the completed shift register is written at stop time.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr[FIFO_AW-1:0]] <= rx_shift;
  end

  assign proc_valid_out = rx_valid_q;
  assign proc_ready_out = tx_ready_q;
  assign proc_data_out  = rx_valid_q ? rx_mem[rx_rd_ptr[FIFO_AW-1:0]] : 8'h00;

  // ---------------------------------------------------------------------------
  // Sticky error flags: clear first, then set, so a same-cycle set wins.
  // ---------------------------------------------------------------------------
  logic rx_overrun_q;
  logic frame_err_q;

  // Sticky error flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (err_clear_in) begin
        rx_overrun_q <= 1'b0;
        frame_err_q  <= 1'b0;
      end
      if (overrun_set) rx_overrun_q <= 1'b1;
      if (rx_bad)      frame_err_q  <= 1'b1;
    end
  end

  assign rx_overrun_out = rx_overrun_q;
  assign frame_err_out  = frame_err_q;

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Directed bench for serial_uart_bridge with CLKS_PER_BIT=4, FIFO_AW=3.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_uart_bridge;

  localparam int CPB   = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] proc_data_out;
  logic       proc_valid_out;
  logic       proc_ready_out;
  logic [7:0] proc_data_in = 8'h00;
  logic       proc_wren_in = 1'b0;
  logic       proc_rden_in = 1'b0;
  logic       uart_rx_in   = 1'b1;
  logic       uart_tx_out;
  logic       err_clear_in = 1'b0;
  logic       rx_overrun_out;
  logic       frame_err_out;

  always #5 clock = ~clock;

  serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .proc_data_out  (proc_data_out),
    .proc_valid_out (proc_valid_out),
    .proc_ready_out (proc_ready_out),
    .proc_data_in   (proc_data_in),
    .proc_wren_in   (proc_wren_in),
    .proc_rden_in   (proc_rden_in),
    .uart_rx_in     (uart_rx_in),
    .uart_tx_out    (uart_tx_out),
    .err_clear_in   (err_clear_in),
    .rx_overrun_out (rx_overrun_out),
    .frame_err_out  (frame_err_out)
  );

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad   = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic       exp_overrun = 1'b0;
  logic       mon_en = 1'b0;
  logic [7:0] mon_byte;
  logic       mon_start;
  logic       mon_stop;
  logic [7:0] pat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_byte(input logic [7:0] b);
    proc_data_in = b;
    proc_wren_in = 1'b1;
    @(negedge clock);
    proc_wren_in = 1'b0;
  endtask

  // Drives one frame on uart_rx_in; returns right after the stop bit time.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx_in = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx_in = stop_bit;
    repeat (CPB) @(negedge clock);
    uart_rx_in = 1'b1;
  endtask

  // Reference model of the RX FIFO for a well-formed frame.
  task automatic expect_frame(input logic [7:0] b);
    if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(b);
    else exp_overrun = 1'b1;
  endtask

  task automatic read_check(input string tag);
    logic [7:0] e;
    check({tag, "_valid"}, proc_valid_out, 1);
    if (rx_exp_q.size() != 0) begin
      e = rx_exp_q.pop_front();
      check(tag, proc_data_out, e);
    end
    proc_rden_in = 1'b1;
    @(negedge clock);
    proc_rden_in = 1'b0;
  endtask

  task automatic wait_valid(input int limit, input string tag);
    int n = 0;
    while (!proc_valid_out && n < limit) begin
      @(negedge clock);
      n++;
    end
    check(tag, proc_valid_out, 1);
  endtask

  task automatic clear_errors();
    err_clear_in = 1'b1;
    @(negedge clock);
    err_clear_in = 1'b0;
  endtask

  // ---------------- TX line monitor (scoreboard consumer) ----------------
  initial begin : tx_monitor
    forever begin
      @(negedge clock);
      if (mon_en && uart_tx_out === 1'b0) begin
        @(negedge clock);
        mon_start = uart_tx_out;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          mon_byte[i] = uart_tx_out;
        end
        repeat (CPB) @(negedge clock);
        mon_stop = uart_tx_out;
        check("tx_start_bit", mon_start, 0);
        check("tx_stop_bit", mon_stop, 1);
        check("tx_frame_expected", tx_exp_q.size() != 0, 1);
        if (tx_exp_q.size() != 0) check("tx_byte", mon_byte, tx_exp_q.pop_front());
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    int n;
    logic exp_line;

    // Reset values while reset is held.
    repeat (3) @(negedge clock);
    check("rst_tx_line", uart_tx_out, 1);
    check("rst_ready", proc_ready_out, 1);
    check("rst_valid", proc_valid_out, 0);
    check("rst_data", proc_data_out, 0);
    check("rst_overrun", rx_overrun_out, 0);
    check("rst_frame_err", frame_err_out, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // 1. Reset in the middle of a 0xFF frame (during its start bit).
    write_byte(8'hFF);
    @(negedge clock);
    check("t1_frame_started", uart_tx_out, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("t1_async_tx_line", uart_tx_out, 1);
    check("t1_ready", proc_ready_out, 1);
    check("t1_valid", proc_valid_out, 0);
    check("t1_overrun", rx_overrun_out, 0);
    check("t1_frame_err", frame_err_out, 0);
    @(negedge clock);
    reset = 1'b1;
    for (int j = 0; j < 45; j++) begin
      check($sformatf("t1_line_idle_%0d", j), uart_tx_out, 1);
      @(negedge clock);
    end

    // 2. Single 0x55 byte, bit-exact line waveform.
    mon_en = 1'b1;
    pat = 8'h55;
    tx_exp_q.push_back(pat);
    write_byte(pat);
    for (int j = 0; j < 52; j++) begin
      if (j == 0) exp_line = 1'b1;
      else if (j <= 4) exp_line = 1'b0;
      else if (j <= 36) exp_line = pat[(j - 5) / 4];
      else exp_line = 1'b1;
      check($sformatf("t2_line_%0d", j), uart_tx_out, exp_line);
      @(negedge clock);
    end

    // 3. One RX frame 0xA3, then a single read.
    expect_frame(8'hA3);
    send_frame(8'hA3, 1'b1);
    wait_valid(3, "t3_valid_latency");
    read_check("t3_data");
    check("t3_valid_after_read", proc_valid_out, 0);
    repeat (3) @(negedge clock);

    // 4. Hold write strobe for ten cycles with data 0x00..0x09.
    for (int k = 0; k < 10; k++) begin
      proc_data_in = 8'(k);
      proc_wren_in = 1'b1;
      check($sformatf("t4_ready_%0d", k), proc_ready_out, (k < 9) ? 1 : 0);
      if (k < 9) tx_exp_q.push_back(8'(k));
      @(negedge clock);
    end
    proc_wren_in = 1'b0;
    check("t4_ready_full", proc_ready_out, 0);
    n = 0;
    while (tx_exp_q.size() != 0 && n < 600) begin
      @(negedge clock);
      n++;
    end
    check("t4_tx_drained", tx_exp_q.size(), 0);
    repeat (4) @(negedge clock);
    check("t4_ready_after", proc_ready_out, 1);

    // 5. Nine RX frames without reading: the ninth overruns.
    for (int k = 0; k < 9; k++) begin
      expect_frame(8'h10 + 8'(k));
      send_frame(8'h10 + 8'(k), 1'b1);
      repeat (2) @(negedge clock);
      check($sformatf("t5_overrun_%0d", k), rx_overrun_out, exp_overrun);
    end
    for (int k = 0; k < 8; k++) read_check($sformatf("t5_read_%0d", k));
    check("t5_valid_empty", proc_valid_out, 0);
    clear_errors();
    exp_overrun = 1'b0;
    check("t5_overrun_cleared", rx_overrun_out, exp_overrun);

    // 6a. Stop bit low: framing error, nothing pushed.
    send_frame(8'h3C, 1'b0);
    repeat (2) @(negedge clock);
    check("t6_frame_err", frame_err_out, 1);
    check("t6_valid", proc_valid_out, 0);
    clear_errors();
    check("t6_frame_err_cleared", frame_err_out, 0);

    // 6b. Framing error while clear is held: set must win.
    err_clear_in = 1'b1;
    send_frame(8'h00, 1'b0);
    @(negedge clock);
    err_clear_in = 1'b0;
    check("t6_set_beats_clear", frame_err_out, 1);
    repeat (2) @(negedge clock);
    clear_errors();
    check("t6_cleared_again", frame_err_out, 0);

    // 6c. One-clock glitch: no push, no flag.
    repeat (3) @(negedge clock);
    uart_rx_in = 1'b0;
    @(negedge clock);
    uart_rx_in = 1'b1;
    repeat (20) @(negedge clock);
    check("t6_glitch_valid", proc_valid_out, 0);
    check("t6_glitch_frame_err", frame_err_out, 0);
    check("t6_glitch_overrun", rx_overrun_out, 0);

    // Read strobe while empty is ignored; receiver still works afterwards.
    proc_rden_in = 1'b1;
    @(negedge clock);
    proc_rden_in = 1'b0;
    expect_frame(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_valid(3, "t6_post_valid");
    read_check("t6_post_data");
    check("t6_post_empty", proc_valid_out, 0);

    check("end_tx_queue_empty", tx_exp_q.size(), 0);
    check("end_rx_queue_empty", rx_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_uart_bridge.md
Name: serial_uart_bridge

Overview:
Device-side endpoint of the processor's byte-wide serial IO port (the serial_* ports routed through data memory).
- Bytes written by the processor are buffered and transmitted as 8N1 UART frames on a physical TX line.
- UART frames received on the RX line are buffered and presented to the processor as serial_in / serial_valid_in.
- Sits at the top level between the processor and the board UART pins.

Parameters:
CLKS_PER_BIT, 434, clocks per UART bit (50 MHz / 115200); minimum 4.
FIFO_AW, 3, address width of each FIFO; depth = 2**FIFO_AW (default 8).

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
proc_data_out  output  8  RX FIFO head byte; drives processor serial_in
proc_valid_out  output  1  RX FIFO non-empty; drives serial_valid_in
proc_ready_out  output  1  TX FIFO not full; drives serial_ready_in
proc_data_in  input  8  byte from processor serial_out
proc_wren_in  input  1  processor serial_wren_out; push strobe
proc_rden_in  input  1  processor serial_rden_out; pop strobe
uart_rx_in  input  1  asynchronous UART receive line, idle high
uart_tx_out  output  1  UART transmit line, idle high
err_clear_in  input  1  synchronous clear of sticky error flags
rx_overrun_out  output  1  sticky: received byte dropped because RX FIFO was full
frame_err_out  output  1  sticky: stop bit sampled low

Behaviour:
- Reset (reset low, asynchronous):
  - FIFOs empty.
  - uart_tx_out=1, proc_valid_out=0, proc_ready_out=1, proc_data_out=0.
  - Both error flags 0; both FSMs in IDLE; RX synchronizer flops set to 1.
  - A frame in progress is abandoned immediately, with no partial push.
- TX FIFO:
  - Push when proc_wren_in && proc_ready_out.
  - A write while full is ignored and raises no flag, because the processor must honour ready.
  - proc_ready_out = !tx_full, registered from count.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, load the baud counter with CLKS_PER_BIT-1, go to START. The first start-bit clock appears the cycle after the pop.
  - START drives 0. DATA drives 8 bits, LSB first. STOP drives 1. Each state lasts exactly CLKS_PER_BIT clocks.
  - After STOP, return to IDLE. If the FIFO is non-empty, the next start bit follows with no idle bit inserted beyond one IDLE cycle.
  - uart_tx_out is registered.
- RX path: uart_rx_in passes through a 2-flop synchronizer before use.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a synchronized 0 moves to START.
  - START: wait CLKS_PER_BIT/2 clocks and resample. If 1, the low was a glitch; return to IDLE. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT clocks (mid-bit), 8 samples, LSB first.
  - STOP: sample after CLKS_PER_BIT clocks.
    - Sample 1 with FIFO not full: push the byte.
    - Sample 1 with FIFO full: drop the byte and set rx_overrun_out.
    - Sample 0: set frame_err_out and discard the byte.
  - Return to IDLE. A new start is accepted only after the line has been seen high in IDLE.
- RX FIFO:
  - Show-ahead: proc_data_out = head, and is valid whenever proc_valid_out=1.
  - Pop on the clock edge where proc_rden_in && proc_valid_out; proc_rden_in while empty is ignored.
  - Simultaneous push and pop when full: both occur, count unchanged, no overrun.
  - Simultaneous push and pop when empty: the push occurs and the pop is ignored.
- Pointers: FIFO_AW+1 bits, so full/empty are distinguished by the MSB; wrap modulo depth.
- Error flags:
  - err_clear_in clears both flags on the next edge.
  - If a set and a clear occur in the same cycle, set wins.

Optional Feature:
SERIAL_LOOPBACK_EN
- Defined: the RX synchronizer input is taken from the internal uart_tx_out register. uart_rx_in is ignored and uart_tx_out is still driven to the pin. Every byte written returns on proc_data_out after one frame time plus synchronizer delay.
- Undefined: RX uses uart_rx_in. No loopback logic is present.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=3):
1. Pull reset low for 1 cycle midway through TX of 0xFF -> uart_tx_out=1 asynchronously; proc_ready_out=1, proc_valid_out=0, both flags 0; no further frame bits after release.
2. Write 0x55 once -> uart_tx_out=0 for 4 clks, then 1,0,1,0,1,0,1,0 at 4 clks each, then 1 for 4 clks; line stays 1 afterwards.
3. Drive an RX frame carrying 0xA3 -> proc_valid_out=1 with proc_data_out=0xA3 within 3 clks of the stop-bit sample; one-cycle proc_rden_in -> proc_valid_out=0.
4. Hold proc_wren_in with data 0x00..0x09 -> exactly 9 bytes accepted (0x00..0x08), proc_ready_out=0; line transmits 0x00..0x08 back-to-back in order.
5. Send 9 RX frames 0x10..0x18 without reading -> rx_overrun_out=1; reads return 0x10..0x17; pulse err_clear_in -> flag 0.
6. RX frame with stop bit 0 -> frame_err_out=1 and proc_valid_out stays 0. Separately, a 1-clock low glitch on uart_rx_in -> no push and no flag.
